// File: rtl/horizontal_out_router.sv
// Horizontal output router: steers two multiplier lanes onto ROM bank write
// codes, walking through four segments of SEG_LEN accepted beats per group.
// All outputs are registered with one cycle of latency.
module horizontal_out_router #(
   parameter int unsigned P_WIDTH  = 64,
   parameter int unsigned NUM_BANK = 8,
   parameter int unsigned SEG_LEN  = 4,
   parameter int unsigned GRP_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [P_WIDTH-1:0]    mul0_in,
   input  logic [P_WIDTH-1:0]    mul1_in,
   output logic                  out_valid,
   output logic [P_WIDTH-1:0]    lane0_out,
   output logic [P_WIDTH-1:0]    lane1_out,
   output logic [2*NUM_BANK-1:0] bank_w,
   output logic [1:0]            seg_idx,
   output logic                  grp_done,
   output logic [GRP_W-1:0]      grp_cnt
);

   // SEG_LEN = 1 still needs a one-bit beat counter that simply stays at 0.
   localparam int unsigned BEAT_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SEG_LEN - 1);

   logic [BEAT_W-1:0]     beat_q;
   logic [1:0]            seg_q;
   logic                  accept;
   logic                  last_beat;
   logic [2*NUM_BANK-1:0] code;
   logic                  sel_l0;
   logic                  sel_l1;

   // A beat is taken only when valid and not being discarded by clear.
   always_comb begin
      accept    = in_valid & ~clear;
      last_beat = (seg_q == 2'd3) && (beat_q == BEAT_LAST);
   end

   // Per-bank write code for the current segment, plus which lanes are in use.
   always_comb begin
      code   = '0;
      sel_l0 = 1'b0;
      sel_l1 = 1'b0;
      for (int unsigned k = 0; k < NUM_BANK; k++) begin
         unique case (seg_q)
            2'd0: begin
               if (k == 0)          code[2*k +: 2] = 2'd1;
               else if (k % 2 == 0) code[2*k +: 2] = 2'd2;
            end
            2'd1: if (k % 2 == 1) code[2*k +: 2] = 2'd1;
            2'd2: if (k % 2 == 1) code[2*k +: 2] = 2'd2;
            2'd3: if (k != 0 && k % 2 == 0) code[2*k +: 2] = 2'd1;
            default: ;
         endcase
      end
      for (int unsigned k = 0; k < NUM_BANK; k++) begin
         if (code[2*k +: 2] == 2'd1) sel_l0 = 1'b1;
         if (code[2*k +: 2] == 2'd2) sel_l1 = 1'b1;
      end
   end

   // Position counters: clear wins over valid; gaps hold the position.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_q <= '0;
         seg_q  <= '0;
      end else if (clear) begin
         beat_q <= '0;
         seg_q  <= '0;
      end else if (in_valid) begin
         if (beat_q == BEAT_LAST) begin
            beat_q <= '0;
            seg_q  <= seg_q + 2'd1;
         end else begin
            beat_q <= beat_q + BEAT_W'(1);
         end
      end
   end

   // Registered outputs; everything but seg_idx and grp_cnt returns to zero
   // after a cycle with no accepted beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         lane0_out <= '0;
         lane1_out <= '0;
         bank_w    <= '0;
         seg_idx   <= 2'd0;
         grp_done  <= 1'b0;
         grp_cnt   <= '0;
      end else begin
         out_valid <= accept;
         bank_w    <= accept ? code : '0;
         lane0_out <= (accept && sel_l0) ? mul0_in : '0;
         lane1_out <= (accept && sel_l1) ? mul1_in : '0;
         grp_done  <= accept && last_beat;
         if (accept) seg_idx <= seg_q;
         if (accept && last_beat) grp_cnt <= grp_cnt + GRP_W'(1);
      end
   end

endmodule

// File: tb/tb_horizontal_out_router.sv
// Randomized self-checking bench for horizontal_out_router with a
// group-position reference model plus directed bank-code checks.
module tb_horizontal_out_router;

   localparam int unsigned PW = 64;
   localparam int unsigned NB = 8;
   localparam int unsigned SL = 4;
   localparam int unsigned GW = 8;
   localparam int unsigned GRP_BEATS = 4 * SL;

   logic            clk = 1'b0;
   logic            rst_n, clear, in_valid;
   logic [PW-1:0]   mul0_in, mul1_in;
   logic            out_valid, grp_done;
   logic [PW-1:0]   lane0_out, lane1_out;
   logic [2*NB-1:0] bank_w;
   logic [1:0]      seg_idx;
   logic [GW-1:0]   grp_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: accepted beats into current group, group count.
   int mpos = 0;
   int mgrp = 0;
   int done_pulses = 0;

   logic [15:0] seg_tbl [4];

   horizontal_out_router #(
      .P_WIDTH (PW),
      .NUM_BANK(NB),
      .SEG_LEN (SL),
      .GRP_W   (GW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .mul0_in  (mul0_in),
      .mul1_in  (mul1_in),
      .out_valid(out_valid),
      .lane0_out(lane0_out),
      .lane1_out(lane1_out),
      .bank_w   (bank_w),
      .seg_idx  (seg_idx),
      .grp_done (grp_done),
      .grp_cnt  (grp_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bank codes straight from the segment rules.
   function automatic logic [2*NB-1:0] bank_of(input int seg);
      logic [2*NB-1:0] r;
      int c;
      r = '0;
      for (int k = 0; k < NB; k++) begin
         case (seg)
            0:       c = (k == 0) ? 1 : ((k % 2 == 0) ? 2 : 0);
            1:       c = (k % 2 == 1) ? 1 : 0;
            2:       c = (k % 2 == 1) ? 2 : 0;
            default: c = (k != 0 && k % 2 == 0) ? 1 : 0;
         endcase
         r[2*k +: 2] = 2'(c);
      end
      return r;
   endfunction

   // One clock: drive at negedge, predict, then compare just after posedge.
   task automatic step(input logic r, input logic c, input logic v,
                       input logic [PW-1:0] m0, input logic [PW-1:0] m1);
      logic            e_valid, e_done;
      logic [2*NB-1:0] e_bank;
      logic [PW-1:0]   e_l0, e_l1;
      int              seg;
      bit              has1, has2;
      @(negedge clk);
      rst_n = r; clear = c; in_valid = v; mul0_in = m0; mul1_in = m1;
      e_valid = 1'b0; e_done = 1'b0; e_bank = '0; e_l0 = '0; e_l1 = '0; seg = 0;
      if (!r) begin
         mpos = 0;
         mgrp = 0;
      end else if (c) begin
         mpos = 0;
      end else if (v) begin
         seg     = mpos / SL;
         e_valid = 1'b1;
         e_bank  = bank_of(seg);
         has1 = 0; has2 = 0;
         for (int k = 0; k < NB; k++) begin
            if (e_bank[2*k +: 2] == 2'd1) has1 = 1;
            if (e_bank[2*k +: 2] == 2'd2) has2 = 1;
         end
         e_l0 = has1 ? m0 : '0;
         e_l1 = has2 ? m1 : '0;
         e_done = (mpos == GRP_BEATS - 1);
         if (e_done) mgrp = (mgrp + 1) % (1 << GW);
         mpos = (mpos + 1) % GRP_BEATS;
      end
      @(posedge clk);
      #1;
      check("out_valid", 64'(out_valid), 64'(e_valid));
      check("bank_w", 64'(bank_w), 64'(e_bank));
      check("lane0_out", lane0_out, e_l0);
      check("lane1_out", lane1_out, e_l1);
      check("grp_done", 64'(grp_done), 64'(e_done));
      check("grp_cnt", 64'(grp_cnt), 64'(mgrp));
      if (e_valid) check("seg_idx", 64'(seg_idx), 64'(seg));
      if (grp_done) done_pulses++;
   endtask

   task automatic beat();
      step(1'b1, 1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
   endtask

   initial begin
      logic [GW-1:0] cnt_before;
      int accepted;
      seg_tbl[0] = 16'h2221; seg_tbl[1] = 16'h4444;
      seg_tbl[2] = 16'h8888; seg_tbl[3] = 16'h1110;
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; mul0_in = '0; mul1_in = '0;

      // Reset with activity on the inputs must still leave everything zero.
      step(1'b0, 1'b0, 1'b1, 64'h1, 64'h2);
      step(1'b0, 1'b1, 1'b1, 64'h3, 64'h4);

      // One full group against the literal code table.
      for (int i = 0; i < 16; i++) begin
         beat();
         check("grp1_table", 64'(bank_w), 64'(seg_tbl[i/4]));
         check("grp1_done", 64'(grp_done), 64'(i == 15));
      end
      check("grp1_cnt", 64'(grp_cnt), 64'd1);

      // Gap after beat 6 pauses the group.
      for (int i = 0; i < 6; i++) beat();
      for (int i = 0; i < 3; i++) begin
         idle();
         check("gap_valid", 64'(out_valid), 64'd0);
         check("gap_bank", 64'(bank_w), 64'd0);
      end
      beat();
      check("resume_bank", 64'(bank_w), 64'h4444);
      for (int i = 7; i < 16; i++) beat();

      // Clear after beat 10 with valid high drops that beat.
      for (int i = 0; i < 10; i++) beat();
      cnt_before = grp_cnt;
      step(1'b1, 1'b1, 1'b1, 64'hdead, 64'hbeef);
      check("clr_drop", 64'(out_valid), 64'd0);
      beat();
      check("clr_seg", 64'(seg_idx), 64'd0);
      check("clr_bank", 64'(bank_w), 64'h2221);
      check("clr_cnt", 64'(grp_cnt), 64'(cnt_before));
      for (int i = 1; i < 16; i++) beat();

      // Reset mid segment 2.
      for (int i = 0; i < 9; i++) beat();
      step(1'b0, 1'b0, 1'b1, 64'h5, 64'h6);
      check("rst_cnt", 64'(grp_cnt), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      beat();
      check("rst_seg", 64'(seg_idx), 64'd0);
      check("rst_bank", 64'(bank_w), 64'h2221);

      // Segment 1 lane steering with fixed operands.
      for (int i = 1; i < 4; i++) beat();
      step(1'b1, 1'b0, 1'b1, 64'd5, 64'd7);
      check("seg1_l0", lane0_out, 64'd5);
      check("seg1_l1", lane1_out, 64'd0);

      // 256 groups from reset with random gaps: counter must wrap to 0.
      step(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
      done_pulses = 0;
      accepted = 0;
      while (accepted < 256 * GRP_BEATS) begin
         if ($urandom_range(3) != 0) begin
            beat();
            accepted++;
         end else begin
            idle();
         end
      end
      check("wrap_cnt", 64'(grp_cnt), 64'd0);
      check("wrap_pulses", 64'(done_pulses), 64'd256);

      // Fully random traffic including clears and resets.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(49) != 0), ($urandom_range(19) == 0),
              ($urandom_range(3) != 0), {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/horizontal_out_router.md
HORIZONTAL_OUT_ROUTER -- requirements
Module: horizontal_out_router

Interface
REQ-001 SHALL have parameter P_WIDTH, default 64: data lane width in bits.
REQ-002 SHALL have parameter NUM_BANK, default 8: number of ROM banks driven; even value, at least 2.
REQ-003 SHALL have parameter SEG_LEN, default 4: accepted beats per segment; power of two, at least 1.
REQ-004 SHALL have parameter GRP_W, default 8: width of the group counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port clear, input, 1 bit: synchronous restart of the segment and beat position.
REQ-008 SHALL have port in_valid, input, 1 bit: lane data valid this cycle.
REQ-009 SHALL have port mul0_in, input, P_WIDTH bits: lane 0 multiplier result.
REQ-010 SHALL have port mul1_in, input, P_WIDTH bits: lane 1 multiplier result.
REQ-011 SHALL have port out_valid, output, 1 bit: registered outputs are valid.
REQ-012 SHALL have port lane0_out, output, P_WIDTH bits: registered lane 0 data, zero when no bank selects lane 0.
REQ-013 SHALL have port lane1_out, output, P_WIDTH bits: registered lane 1 data, zero when no bank selects lane 1.
REQ-014 SHALL have port bank_w, output, 2*NUM_BANK bits: per-bank write code; bank k occupies bits [2k+1:2k]. Codes: 0 = idle, 1 = write lane 0, 2 = write lane 1; 3 is never driven.
REQ-015 SHALL have port seg_idx, output, 2 bits: segment of the registered beat.
REQ-016 SHALL have port grp_done, output, 1 bit: one-cycle pulse on the last beat of a group.
REQ-017 SHALL have port grp_cnt, output, GRP_W bits: count of completed groups.

Function
REQ-018 SHALL hold an internal beat counter (0..SEG_LEN-1) and segment counter (0..3); one group is 4*SEG_LEN accepted beats.
REQ-019 SHALL advance the beat counter only on cycles with in_valid=1.
REQ-020 SHALL wrap the beat counter at SEG_LEN-1 and advance the segment counter on that wrap; segment 3 wraps to 0.
REQ-021 SHALL hold both counters while in_valid=0, so a gap pauses the group rather than restarting it.
REQ-022 SHALL zero both counters when clear=1, with priority over in_valid; a beat presented in that same cycle is dropped (out_valid=0 next cycle).
REQ-023 SHALL decode the bank codes from the current segment as follows:
- seg 0: bank0=1; even banks k>=2 =2; all odd banks =0.
- seg 1: odd banks =1; all even banks =0.
- seg 2: odd banks =2; all even banks =0.
- seg 3: bank0=0; even banks k>=2 =1; all odd banks =0.
REQ-024 SHALL register all outputs with latency 1: an input beat accepted at edge N appears on the outputs after edge N.
REQ-025 SHALL drive out_valid=0, bank_w=0, lane0_out=0, lane1_out=0 and grp_done=0 in any cycle following a non-accepted cycle.
REQ-026 SHALL set lane0_out=mul0_in only when some bank code is 1, and lane1_out=mul1_in only when some bank code is 2; otherwise the lane is 0.
REQ-027 SHALL assert grp_done on the output beat of segment 3, beat SEG_LEN-1.
REQ-028 SHALL increment grp_cnt on that same beat, wrapping modulo 2^GRP_W.
REQ-029 SHALL leave grp_cnt unchanged on clear.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, zero the counters, grp_cnt and every output regardless of clear or in_valid.
REQ-031 SHALL on reset mid-group discard the partial group, and SHALL accept the first beat after release as segment 0, beat 0.

Verification
REQ-032 Reset, then 16 continuous valid beats with SEG_LEN=4 and NUM_BANK=8 -> beats 1-4: bank_w=16'h2221; beats 5-8: 16'h4444; beats 9-12: 16'h8888; beats 13-16: 16'h1110. grp_done high only on beat 16; grp_cnt=1.
REQ-033 Drop in_valid for 3 cycles after beat 6 -> out_valid=0 and bank_w=0 for those 3 cycles; beat 7 resumes in seg 1 with bank_w=16'h4444.
REQ-034 Assert clear after beat 10 while in_valid=1 -> that beat is dropped; the next accepted beat has seg_idx=0 and bank_w=16'h2221; grp_cnt is unchanged.
REQ-035 Assert rst_n=0 mid-segment 2 -> next cycle all outputs and grp_cnt are 0; after release the first beat decodes as seg 0.
REQ-036 Run 256 groups with GRP_W=8 -> grp_cnt wraps to 0, with a grp_done pulse every 16 beats; in segment 1, mul0=5 and mul1=7 -> lane0_out=5, lane1_out=0.
